// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/data requesters, mem_port_arbiter and the shared word memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_stall, dm_rdata, dm_stall, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester/backend side
  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_stall, dm_rdata, dm_stall, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency word memory between instruction fetch
// and data access; the loser is held off with a combinational stall.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic {GNT_IF, GNT_DM} grant_t;

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  grant_t            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic served_if_c, served_dm_c, if_elig_c, dm_elig_c;

  // The requester completed in DONE sits out this round so it can advance.
  assign served_if_c = (state_q == DONE) && (grant_q == GNT_IF);
  assign served_dm_c = (state_q == DONE) && (grant_q == GNT_DM);
  assign if_elig_c   = bus.if_req & ~served_if_c;
  assign dm_elig_c   = (bus.dm_read | bus.dm_write) & ~served_dm_c;

  assign bus.if_stall  = if_elig_c;
  assign bus.dm_stall  = dm_elig_c;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_IF;
      last_grant_q <= GNT_DM;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    case (state_q)
      IDLE, DONE: begin
        if (if_elig_c || dm_elig_c) begin
          if (if_elig_c && dm_elig_c) begin
            grant_d = (last_grant_q == GNT_IF) ? GNT_DM : GNT_IF;
          end else if (if_elig_c) begin
            grant_d = GNT_IF;
          end else begin
            grant_d = GNT_DM;
          end
          last_grant_d = grant_d;
          mem_en_d     = 1'b1;
          cnt_d        = CNT_W'(MEM_LAT);
          state_d      = WAIT;
          if (grant_d == GNT_IF) begin
            mem_addr_d = bus.if_addr;
            mem_we_d   = 1'b0;
          end else begin
            // A simultaneous read+write is issued as a write.
            mem_addr_d  = bus.dm_addr;
            mem_we_d    = bus.dm_write;
            mem_wdata_d = bus.dm_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          if (grant_q == GNT_IF) begin
            if_rdata_d = bus.mem_rdata;
          end else if (!mem_we_q) begin
            dm_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency backend model.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Backend contents: address 4 holds an addi, every other word reads C0DE_0000 | address.
  function automatic logic [31:0] rom(input logic [9:0] a);
    if (a == 10'h004) return 32'h00A0_0093;
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Read data turns valid MEM_LAT cycles after the mem_en cycle; poisoned before that.
  int         rd_cnt  = 0;
  logic [9:0] rd_addr = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      rd_addr       <= bus.mem_addr;
      rd_cnt        <= int'(MEM_LAT) - 1;
      bus.mem_rdata <= 32'hBAD0_BAD0;
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
      if (rd_cnt == 1) bus.mem_rdata <= rom(rd_addr);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_req = 1'b1; bus.if_addr = '0;
    bus.dm_read = 1'b0; bus.dm_write = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

    // Reset values, stall following its request while in reset
    tick(); #1;
    chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
    chk("rst_if_stall_hi", 32'(bus.if_stall), 32'h1);
    chk("rst_dm_stall", 32'(bus.dm_stall), 32'h0);
    bus.if_req = 1'b0; #1;
    chk("rst_if_stall_lo", 32'(bus.if_stall), 32'h0);
    rst = 1'b1;

    // Fetch only
    tick(); bus.if_req = 1'b1; bus.if_addr = 10'h004; #1;
    chk("f_stall_T", 32'(bus.if_stall), 32'h1);
    tick(); #1;
    chk("f_mem_en_T1", 32'(bus.mem_en), 32'h1);
    chk("f_mem_addr_T1", 32'(bus.mem_addr), 32'h004);
    chk("f_mem_we_T1", 32'(bus.mem_we), 32'h0);
    tick(); #1;
    chk("f_mem_en_T2", 32'(bus.mem_en), 32'h0);
    chk("f_stall_T2", 32'(bus.if_stall), 32'h1);
    tick(2); #1;
    chk("f_stall_T4", 32'(bus.if_stall), 32'h1);
    chk("f_rdata_T4", bus.if_rdata, 32'h0);
    tick(); #1;
    chk("f_stall_T5", 32'(bus.if_stall), 32'h0);
    chk("f_rdata_T5", bus.if_rdata, 32'h00A0_0093);
    bus.if_req = 1'b0;

    // Reset again so the next contention is decided from the reset last_grant
    tick(); rst = 1'b0; #1;
    chk("rst2_if_rdata", bus.if_rdata, 32'h0);
    rst = 1'b1;

    // Contention: IF first, DM issued from DONE
    tick();
    bus.if_req = 1'b1; bus.if_addr = 10'h008;
    bus.dm_read = 1'b1; bus.dm_addr = 10'h020; #1;
    chk("c_if_stall_T", 32'(bus.if_stall), 32'h1);
    chk("c_dm_stall_T", 32'(bus.dm_stall), 32'h1);
    tick(); #1;
    chk("c_mem_en_T1", 32'(bus.mem_en), 32'h1);
    chk("c_mem_addr_T1", 32'(bus.mem_addr), 32'h008);
    tick(4); #1;
    chk("c_if_stall_T5", 32'(bus.if_stall), 32'h0);
    chk("c_if_rdata_T5", bus.if_rdata, 32'hC0DE_0008);
    chk("c_dm_stall_T5", 32'(bus.dm_stall), 32'h1);
    chk("c_mem_en_T5", 32'(bus.mem_en), 32'h0);
    bus.if_req = 1'b0;
    tick(); #1;
    chk("c_mem_en_T6", 32'(bus.mem_en), 32'h1);
    chk("c_mem_addr_T6", 32'(bus.mem_addr), 32'h020);
    chk("c_mem_we_T6", 32'(bus.mem_we), 32'h0);
    tick(3); #1;
    chk("c_dm_stall_T9", 32'(bus.dm_stall), 32'h1);
    tick(); #1;
    chk("c_dm_stall_T10", 32'(bus.dm_stall), 32'h0);
    chk("c_dm_rdata_T10", bus.dm_rdata, 32'hC0DE_0020);
    bus.dm_read = 1'b0;

    // Write
    tick();
    bus.dm_write = 1'b1; bus.dm_addr = 10'h010; bus.dm_wdata = 32'hDEAD_BEEF; #1;
    chk("w_stall_T", 32'(bus.dm_stall), 32'h1);
    tick(); #1;
    chk("w_mem_en_T1", 32'(bus.mem_en), 32'h1);
    chk("w_mem_we_T1", 32'(bus.mem_we), 32'h1);
    chk("w_mem_addr_T1", 32'(bus.mem_addr), 32'h010);
    chk("w_mem_wdata_T1", bus.mem_wdata, 32'hDEAD_BEEF);
    tick(); #1;
    chk("w_mem_en_T2", 32'(bus.mem_en), 32'h0);
    tick(2); #1;
    chk("w_stall_T4", 32'(bus.dm_stall), 32'h1);
    tick(); #1;
    chk("w_stall_T5", 32'(bus.dm_stall), 32'h0);
    chk("w_dm_rdata_T5", bus.dm_rdata, 32'hC0DE_0020);
    bus.dm_write = 1'b0;

    // Round-robin: six accesses, issues every 5 cycles alternating IF/DM
    tick();
    bus.if_req = 1'b1; bus.if_addr = 10'h040;
    bus.dm_read = 1'b1; bus.dm_addr = 10'h080;
    for (int c = 1; c <= 30; c++) begin
      tick(); #1;
      chk($sformatf("rr_mem_en_c%0d", c), 32'(bus.mem_en),
          (c <= 26 && (c - 1) % 5 == 0) ? 32'h1 : 32'h0);
      if (c <= 26 && (c - 1) % 5 == 0)
        chk($sformatf("rr_mem_addr_c%0d", c), 32'(bus.mem_addr),
            (((c - 1) / 5) % 2 == 0) ? 32'h040 : 32'h080);
      if (c == 25) chk("rr_if_rdata", bus.if_rdata, 32'hC0DE_0040);
      if (c == 30) begin
        chk("rr_dm_stall", 32'(bus.dm_stall), 32'h0);
        chk("rr_dm_rdata", bus.dm_rdata, 32'hC0DE_0080);
      end
    end
    bus.if_req = 1'b0; bus.dm_read = 1'b0;

    // Read+write treated as write; IF request withdrawn before grant is never issued
    tick();
    bus.dm_read = 1'b1; bus.dm_write = 1'b1;
    bus.dm_addr = 10'h030; bus.dm_wdata = 32'h1234_5678; #1;
    chk("rw_mem_en_T", 32'(bus.mem_en), 32'h0);
    tick(); #1;
    chk("rw_mem_en_T1", 32'(bus.mem_en), 32'h1);
    chk("rw_mem_we_T1", 32'(bus.mem_we), 32'h1);
    chk("rw_mem_addr_T1", 32'(bus.mem_addr), 32'h030);
    chk("rw_mem_wdata_T1", bus.mem_wdata, 32'h1234_5678);
    tick(); bus.if_req = 1'b1; bus.if_addr = 10'h044; #1;
    chk("wd_if_stall", 32'(bus.if_stall), 32'h1);
    tick(); bus.if_req = 1'b0;
    tick(2); #1;
    chk("rw_dm_stall_T5", 32'(bus.dm_stall), 32'h0);
    chk("rw_dm_rdata_T5", bus.dm_rdata, 32'hC0DE_0080);
    bus.dm_read = 1'b0; bus.dm_write = 1'b0;
    for (int c = 6; c <= 10; c++) begin
      tick(); #1;
      chk($sformatf("wd_no_issue_c%0d", c), 32'(bus.mem_en), 32'h0);
    end

    // Reset in the WAIT cycle with cnt=1, then a fresh issue
    tick(); bus.if_req = 1'b1; bus.if_addr = 10'h050;
    tick(); #1;
    chk("ra_mem_en_T1", 32'(bus.mem_en), 32'h1);
    chk("ra_mem_addr_T1", 32'(bus.mem_addr), 32'h050);
    tick(2); #1;
    chk("ra_if_rdata_pre", bus.if_rdata, 32'hC0DE_0040);
    rst = 1'b0; #1;
    chk("ra_mem_en", 32'(bus.mem_en), 32'h0);
    chk("ra_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("ra_mem_we", 32'(bus.mem_we), 32'h0);
    chk("ra_mem_wdata", bus.mem_wdata, 32'h0);
    chk("ra_if_rdata", bus.if_rdata, 32'h0);
    chk("ra_dm_rdata", bus.dm_rdata, 32'h0);
    chk("ra_if_stall", 32'(bus.if_stall), 32'h1);
    tick(); rst = 1'b1; #1;
    chk("ra_mem_en_rel", 32'(bus.mem_en), 32'h0);
    tick(); #1;
    chk("ra_mem_en_T1b", 32'(bus.mem_en), 32'h1);
    chk("ra_mem_addr_T1b", 32'(bus.mem_addr), 32'h050);
    tick(); #1;
    chk("ra_mem_en_T2b", 32'(bus.mem_en), 32'h0);
    tick(3); #1;
    chk("ra_if_stall_done", 32'(bus.if_stall), 32'h0);
    chk("ra_if_rdata_done", bus.if_rdata, 32'hC0DE_0050);
    bus.if_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
